cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
Run-control stage directly downstream of the free-running clock divider. Consumes the divider's 32-bit `clkdiv` count and a raw push-button, and produces a single-cycle CPU clock-enable. Run modes: full speed, slow tick, single-step per press, and N-step burst per press. Sits between the divider and the CPU core's enable input on the board-level test harness.

Parameters:
- SLOW_BIT, 24: `clkdiv` bit whose rising edge is the slow-mode tick.
- DB_BIT, 17: `clkdiv` bit whose rising edge is the debounce sample tick.
- DB_CNT, 4: consecutive differing samples needed to flip the debounced level (1..15).
- BURST_W, 8: width of the burst length input.

Ports:
- clk, input, 1: system clock, same clock that drives the divider.
- rst, input, 1: reset, synchronous, active-high.
- clkdiv, input, 32: divider count, sampled on clk.
- mode, input, 2: 00 run, 01 slow, 10 step, 11 burst.
- halt, input, 1: forces cpu_en low; burst progress is held.
- btn_raw, input, 1: asynchronous step button, active-high.
- burst_len, input, BURST_W: pulse count loaded on a burst-mode press.
- cpu_en, output, 1: registered one-cycle (or continuous in run mode) CPU enable.
- busy, output, 1: high while a burst is in progress.
- btn_db, output, 1: debounced button level.
- step_cnt, output, 32: total enables issued.

Behaviour:
- Reset (synchronous, rst high at a clk edge): cpu_en=0, busy=0, btn_db=0, step_cnt=0; synchronizer, debounce counter, and burst counter all 0; FSM=IDLE; previous-bit registers for SLOW_BIT/DB_BIT = 0. Reset mid-burst aborts the burst, and no further pulse is issued.
- Synchronizer: btn_raw passes through 2 flops before use.
- Tick detection: slow_tick = clkdiv[SLOW_BIT] & ~prev_slow; db_tick likewise on DB_BIT. Previous-bit registers update every cycle.
- Debounce: on db_tick, if synced == btn_db, the counter clears. Otherwise the counter increments. When the counter reaches DB_CNT, btn_db <= synced and the counter clears. press = one-cycle internal pulse on the btn_db 0->1 transition.
- cpu_en is registered. en_next is computed from current inputs and state, and cpu_en follows one cycle later. Whenever halt=1, en_next=0.
  - Run mode (00): en_next=1.
  - Slow mode (01): en_next=slow_tick.
  - Step mode (10): en_next=press.
  - Burst mode (11): en_next=1 in the BURST state.
- Burst FSM:
  - IDLE -> BURST on press in mode 11 with burst_len != 0; the counter loads burst_len.
  - In BURST with halt=0, each cycle issues an enable and decrements the counter. Reaching 0 returns to IDLE.
  - halt=1 holds both the counter and the state.
  - A press during BURST is ignored.
  - A mode change away from 11 in BURST returns to IDLE immediately, with no enable that cycle.
  - burst_len=0 means the press is ignored and the FSM stays in IDLE.
  - busy = (state == BURST).
- step_cnt increments by 1 on every cycle where cpu_en=1, and wraps from 0xFFFFFFFF to 0.
- Simultaneous events:
  - halt takes priority over every enable source.
  - A press in modes 00 and 01 has no effect.

Optional Feature:
- STEP_CNT_EN defined: the step_cnt register is present and behaves as above.
- Not defined: the register is removed, and step_cnt is tied to 32'd0.

Test Plan:
- Bench parameters: SLOW_BIT=3, DB_BIT=1, DB_CNT=3; the bench drives clkdiv as a counter.
- Reset, then mode=00, halt=0 -> cpu_en=1 from the 2nd cycle after reset release. With STEP_CNT_EN, step_cnt=10 after 10 enabled cycles.
- mode=01, clkdiv counting 0..63 -> exactly 4 cpu_en pulses, each 1 cycle wide, each 1 cycle after clkdiv[3] rises.
- mode=10, btn_raw bouncing 0/1 every db_tick for 2 samples, then held high -> btn_db rises only after 3 stable differing samples. Exactly 1 cpu_en pulse results; releasing and pressing again gives a 2nd pulse.
- mode=11, burst_len=5, one press -> busy high, then exactly 5 consecutive cpu_en cycles, then busy=0. A second press mid-burst adds no pulses.
- Burst of 8 interrupted:
  - halt=1 after 3 pulses for 4 cycles -> no enables during halt, 5 more after.
  - Repeat with a mode change to 10 after 3 pulses -> busy=0 and no further pulses.
  - Repeat with rst after 3 pulses -> all outputs 0.
- Preload step_cnt near wrap (force or long run) at 0xFFFFFFFF, then 1 enable -> step_cnt=0. burst_len=0 press -> no pulse, busy stays 0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run-control stage between the free-running clock divider and
// the CPU core's clock-enable input.
//
// Turns the divider count and a raw push-button into a registered CPU enable.
// Modes: 00 run (continuous), 01 slow (one enable per rising edge of
// clkdiv[SLOW_BIT]), 10 step (one enable per debounced press), 11 burst
// (burst_len consecutive enables per debounced press).
//
// Ports:
//   clk        system clock (same clock as the divider)
//   rst        synchronous, active-high reset
//   clkdiv     32-bit divider count
//   mode       run-mode select
//   halt       forces cpu_en low; holds burst progress
//   btn_raw    asynchronous step button, active-high
//   burst_len  number of enables loaded on a burst-mode press
//   cpu_en     registered CPU clock-enable
//   busy       high while a burst is in progress
//   btn_db     debounced button level
//   step_cnt   total enables issued (only when STEP_CNT_EN is defined)
//
// Build option: define STEP_CNT_EN to include the step_cnt counter; without
// it step_cnt is tied to zero.
module cpu_step_ctrl #(
  parameter int SLOW_BIT = 24,
  parameter int DB_BIT   = 17,
  parameter int DB_CNT   = 4,
  parameter int BURST_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        clkdiv,
  input  logic [1:0]         mode,
  input  logic               halt,
  input  logic               btn_raw,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cpu_en,
  output logic               busy,
  output logic               btn_db,
  output logic [31:0]        step_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_SLOW  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;
  localparam logic [3:0] DB_LIMIT   = 4'(DB_CNT);

  logic               btn_sync_p0;
  logic               btn_sync_p1;
  logic               prev_slow;
  logic               prev_db;
  logic               slow_tick;
  logic               db_tick;
  logic [3:0]         db_cnt;
  logic               btn_db_d;
  logic               press;
  state_t             state;
  state_t             state_next;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] burst_cnt_next;
  logic               en_next;
  logic               unused_clkdiv;

  // Only two divider bits matter; the reduction keeps the rest of the bus
  // visibly consumed.
  assign unused_clkdiv = ^clkdiv;

  // Stage p0/p1: button synchronizer and divider-bit edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      prev_slow   <= 1'b0;
      prev_db     <= 1'b0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
      prev_slow   <= clkdiv[SLOW_BIT];
      prev_db     <= clkdiv[DB_BIT];
    end
  end

  assign slow_tick = clkdiv[SLOW_BIT] & ~prev_slow;
  assign db_tick   = clkdiv[DB_BIT] & ~prev_db;

  // Debounce: the level flips only after DB_CNT consecutive sample ticks
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= 4'd0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (db_tick) begin
        if (btn_sync_p1 == btn_db) begin
          db_cnt <= 4'd0;
        end else if (db_cnt == DB_LIMIT - 4'd1) begin
          btn_db <= btn_sync_p1;
          db_cnt <= 4'd0;
        end else begin
          db_cnt <= db_cnt + 4'd1;
        end
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    en_next        = 1'b0;

    case (state)
      IDLE: begin
        if (press && (mode == MODE_BURST) && (burst_len != '0)) begin
          state_next     = BURST;
          burst_cnt_next = burst_len;
        end
      end
      BURST: begin
        if (mode != MODE_BURST) begin
          state_next = IDLE;
        end else if (!halt) begin
          burst_cnt_next = burst_cnt - 1'b1;
          if (burst_cnt == BURST_W'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (mode)
      MODE_RUN:   en_next = 1'b1;
      MODE_SLOW:  en_next = slow_tick;
      MODE_STEP:  en_next = press;
      MODE_BURST: en_next = (state == BURST);
      default:    en_next = 1'b0;
    endcase

    // An aborted burst issues nothing in the cycle it is abandoned, whatever
    // the new mode would otherwise produce.
    if ((state == BURST) && (mode != MODE_BURST)) begin
      en_next = 1'b0;
    end
    if (halt) begin
      en_next = 1'b0;
    end
  end

  // Stage p2: registered enable and burst state
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_en    <= 1'b0;
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      cpu_en    <= en_next;
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  assign busy = (state == BURST);

`ifdef STEP_CNT_EN
  logic [31:0] step_cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_r <= 32'd0;
    end else if (cpu_en) begin
      step_cnt_r <= step_cnt_r + 32'd1;
    end
  end

  assign step_cnt = step_cnt_r;
`else
  assign step_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl with SLOW_BIT=3, DB_BIT=1, DB_CNT=3.
// clkdiv advances by one every clock, so a debounce sample tick falls on
// every count with clkdiv[1:0]==2 and a slow tick on every clkdiv[3:0]==8.
module tb_cpu_step_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] clkdiv;
  logic [1:0]  mode;
  logic        halt;
  logic        btn_raw;
  logic [7:0]  burst_len;
  logic        cpu_en;
  logic        busy;
  logic        btn_db;
  logic [31:0] step_cnt;

  int n_assert;
  int n_fail;
  int en_count;

  cpu_step_ctrl #(
    .SLOW_BIT(3),
    .DB_BIT  (1),
    .DB_CNT  (3),
    .BURST_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clkdiv   (clkdiv),
    .mode     (mode),
    .halt     (halt),
    .btn_raw  (btn_raw),
    .burst_len(burst_len),
    .cpu_en   (cpu_en),
    .busy     (busy),
    .btn_db   (btn_db),
    .step_cnt (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: outputs are sampled 1 time unit after the edge, enables are
  // tallied, then the divider count advances.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cpu_en === 1'b1) en_count++;
    clkdiv = clkdiv + 32'd1;
  endtask

  // Runs until the DUT has just consumed a debounce sample tick.
  task automatic db_wait();
    logic [31:0] v;
    logic        hit;
    hit = 1'b0;
    for (int i = 0; i < 8 && !hit; i++) begin
      v = clkdiv;
      cyc();
      if (v[1:0] == 2'd2) hit = 1'b1;
    end
    if (!hit) begin
      n_assert++;
      n_fail++;
      $display("FAIL db_wait_timeout: no sample tick within 8 cycles");
    end
  endtask

  // Drives the button to lvl and waits exactly the three samples needed for
  // the debounced level to follow.
  task automatic set_btn(input logic lvl);
    db_wait();
    btn_raw = lvl;
    db_wait();
    db_wait();
    db_wait();
    n_assert++;
    if (btn_db !== lvl) begin
      n_fail++;
      $display("FAIL set_btn_level: btn_db=%b expected %b", btn_db, lvl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_assert++;
    if ({cpu_en, busy, btn_db} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: {cpu_en,busy,btn_db}=%b expected 000", {cpu_en, busy, btn_db});
    end
    n_assert++;
    if (step_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_step_cnt: step_cnt=%0d expected 0", step_cnt);
    end
  endtask

  task automatic test_run();
    logic [31:0] exp_cnt;
    mode = 2'b00;
    rst  = 1'b0;
    cyc();
    n_assert++;
    if (cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL run_first_enable: cpu_en=%b expected 1", cpu_en);
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_assert++;
      if (cpu_en !== 1'b1) begin
        n_fail++;
        $display("FAIL run_enable[%0d]: cpu_en=%b expected 1", i, cpu_en);
      end
    end
`ifdef STEP_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    n_assert++;
    if (step_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL run_step_cnt: step_cnt=%0d expected %0d", step_cnt, exp_cnt);
    end
    halt = 1'b1;
    cyc();
    cyc();
    n_assert++;
    if (cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL run_halt: cpu_en=%b expected 0", cpu_en);
    end
    halt = 1'b0;
  endtask

  task automatic test_slow();
    logic [31:0] v;
    logic        exp;
    int          e0;
    mode   = 2'b01;
    clkdiv = 32'd0;
    cyc();
    clkdiv = 32'd0;
    e0 = en_count;
    for (int i = 0; i < 64; i++) begin
      v = clkdiv;
      cyc();
      exp = (v[3:0] == 4'd8);
      n_assert++;
      if (cpu_en !== exp) begin
        n_fail++;
        $display("FAIL slow_enable[clkdiv=%0d]: cpu_en=%b expected %b", v, cpu_en, exp);
      end
    end
    n_assert++;
    if (en_count - e0 != 4) begin
      n_fail++;
      $display("FAIL slow_pulse_count: pulses=%0d expected 4", en_count - e0);
    end
  endtask

  task automatic test_step();
    int e0;
    mode = 2'b10;
    db_wait();
    e0 = en_count;
    btn_raw = 1'b1;
    db_wait();
    btn_raw = 1'b0;
    db_wait();
    btn_raw = 1'b1;
    db_wait();
    n_assert++;
    if (btn_db !== 1'b0) begin
      n_fail++;
      $display("FAIL step_db_after1: btn_db=%b expected 0", btn_db);
    end
    db_wait();
    n_assert++;
    if (btn_db !== 1'b0) begin
      n_fail++;
      $display("FAIL step_db_after2: btn_db=%b expected 0", btn_db);
    end
    db_wait();
    n_assert++;
    if ({btn_db, cpu_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL step_db_after3: {btn_db,cpu_en}=%b expected 10", {btn_db, cpu_en});
    end
    cyc();
    n_assert++;
    if (cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL step_pulse: cpu_en=%b expected 1", cpu_en);
    end
    cyc();
    n_assert++;
    if (cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL step_pulse_width: cpu_en=%b expected 0", cpu_en);
    end
    for (int i = 0; i < 6; i++) cyc();
    n_assert++;
    if (en_count - e0 != 1) begin
      n_fail++;
      $display("FAIL step_first_count: pulses=%0d expected 1", en_count - e0);
    end
    set_btn(1'b0);
    set_btn(1'b1);
    for (int i = 0; i < 4; i++) cyc();
    n_assert++;
    if (en_count - e0 != 2) begin
      n_fail++;
      $display("FAIL step_second_count: pulses=%0d expected 2", en_count - e0);
    end
    set_btn(1'b0);
  endtask

  task automatic test_burst();
    int e0;
    mode      = 2'b11;
    burst_len = 8'd5;
    e0 = en_count;
    set_btn(1'b1);
    cyc();
    n_assert++;
    if ({busy, cpu_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL burst_start: {busy,cpu_en}=%b expected 10", {busy, cpu_en});
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_assert++;
      if (cpu_en !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_pulse[%0d]: cpu_en=%b expected 1", i, cpu_en);
      end
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_end_busy: busy=%b expected 0", busy);
    end
    cyc();
    n_assert++;
    if (cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_after: cpu_en=%b expected 0", cpu_en);
    end
    n_assert++;
    if (en_count - e0 != 5) begin
      n_fail++;
      $display("FAIL burst_count: pulses=%0d expected 5", en_count - e0);
    end
    set_btn(1'b0);
  endtask

  task automatic test_burst_repress();
    int e0;
    burst_len = 8'd40;
    e0 = en_count;
    set_btn(1'b1);
    set_btn(1'b0);
    set_btn(1'b1);
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL repress_mid_burst: busy=%b expected 1", busy);
    end
    for (int i = 0; i < 20; i++) cyc();
    n_assert++;
    if ({busy, cpu_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL repress_done: {busy,cpu_en}=%b expected 00", {busy, cpu_en});
    end
    n_assert++;
    if (en_count - e0 != 40) begin
      n_fail++;
      $display("FAIL repress_count: pulses=%0d expected 40", en_count - e0);
    end
    set_btn(1'b0);
  endtask

  // Starts a burst of 8 and runs until three enables have been observed.
  task automatic start_burst8();
    burst_len = 8'd8;
    set_btn(1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_assert++;
      if ({busy, cpu_en} !== 2'b11) begin
        n_fail++;
        $display("FAIL burst8_lead[%0d]: {busy,cpu_en}=%b expected 11", i, {busy, cpu_en});
      end
    end
  endtask

  task automatic test_burst_halt();
    int e0;
    mode = 2'b11;
    start_burst8();
    halt = 1'b1;
    e0 = en_count;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_assert++;
      if ({busy, cpu_en} !== 2'b10) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: {busy,cpu_en}=%b expected 10", i, {busy, cpu_en});
      end
    end
    halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_assert++;
      if (cpu_en !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_resume[%0d]: cpu_en=%b expected 1", i, cpu_en);
      end
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_end_busy: busy=%b expected 0", busy);
    end
    cyc();
    n_assert++;
    if (en_count - e0 != 5) begin
      n_fail++;
      $display("FAIL halt_count: pulses after halt=%0d expected 5", en_count - e0);
    end
    set_btn(1'b0);
  endtask

  task automatic test_burst_mode_change();
    int e0;
    mode = 2'b11;
    start_burst8();
    mode = 2'b10;
    e0 = en_count;
    cyc();
    n_assert++;
    if ({busy, cpu_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL modechg_abort: {busy,cpu_en}=%b expected 00", {busy, cpu_en});
    end
    for (int i = 0; i < 8; i++) cyc();
    n_assert++;
    if (en_count - e0 != 0) begin
      n_fail++;
      $display("FAIL modechg_count: pulses=%0d expected 0", en_count - e0);
    end
    set_btn(1'b0);
  endtask

  task automatic test_burst_reset();
    int e0;
    mode = 2'b11;
    start_burst8();
    rst     = 1'b1;
    btn_raw = 1'b0;
    cyc();
    n_assert++;
    if ({cpu_en, busy, btn_db, step_cnt} !== 35'd0) begin
      n_fail++;
      $display("FAIL burst_reset_outputs: cpu_en=%b busy=%b btn_db=%b step_cnt=%0d expected all 0",
               cpu_en, busy, btn_db, step_cnt);
    end
    rst = 1'b0;
    e0 = en_count;
    for (int i = 0; i < 10; i++) cyc();
    n_assert++;
    if ((en_count - e0 != 0) || (busy !== 1'b0)) begin
      n_fail++;
      $display("FAIL burst_reset_after: pulses=%0d busy=%b expected 0 and 0", en_count - e0, busy);
    end
  endtask

  task automatic test_burst_zero();
    int e0;
    mode      = 2'b11;
    burst_len = 8'd0;
    e0 = en_count;
    set_btn(1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_assert++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_busy[%0d]: busy=%b expected 0", i, busy);
      end
    end
    n_assert++;
    if (en_count - e0 != 0) begin
      n_fail++;
      $display("FAIL zero_count: pulses=%0d expected 0", en_count - e0);
    end
    set_btn(1'b0);
  endtask

  task automatic test_wrap();
    mode = 2'b10;
    cyc();
`ifdef STEP_CNT_EN
    force dut.step_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.step_cnt_r;
    n_assert++;
    if (step_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: step_cnt=%h expected ffffffff", step_cnt);
    end
    mode = 2'b00;
    cyc();
    mode = 2'b10;
    cyc();
    n_assert++;
    if ({cpu_en, step_cnt} !== 33'd0) begin
      n_fail++;
      $display("FAIL wrap_result: cpu_en=%b step_cnt=%h expected 0 and 00000000", cpu_en, step_cnt);
    end
`else
    mode = 2'b00;
    cyc();
    cyc();
    n_assert++;
    if (step_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL step_cnt_tied: step_cnt=%h expected 00000000", step_cnt);
    end
    mode = 2'b10;
    cyc();
`endif
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    en_count  = 0;
    rst       = 1'b1;
    clkdiv    = 32'd0;
    mode      = 2'b00;
    halt      = 1'b0;
    btn_raw   = 1'b0;
    burst_len = 8'd0;

    test_reset();
    test_run();
    test_slow();
    test_step();
    test_burst();
    test_burst_repress();
    test_burst_halt();
    test_burst_mode_change();
    test_burst_reset();
    test_burst_zero();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
